// File: rtl/axi_logpwr_pkg.sv
// rtl/axi_logpwr_pkg.sv - shared states, source indices and defaults for the logpwr scheduler
package axi_logpwr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_e;

  localparam logic SRC0        = 1'b0;
  localparam logic SRC1        = 1'b1;
  localparam int   DEF_WIDTH   = 32;
  localparam int   DEF_MAX_LEN = 1024;

endpackage

// File: rtl/axi_logpwr_sched_if.sv
// rtl/axi_logpwr_sched_if.sv - stream bundle with source-index sideband
interface axi_logpwr_sched_if
  import axi_logpwr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] tdata;
  logic             tlast;
  logic             tvalid;
  logic             tready;
  logic             tuser;

  modport master (output tdata, tlast, tvalid, tuser, input tready);
  modport slave  (input tdata, tlast, tvalid, tuser, output tready);

endinterface

// File: rtl/axi_logpwr_sched_pipe_reg.sv
// rtl/axi_logpwr_sched_pipe_reg.sv - single-entry output register slice
module axi_pipe_reg
  import axi_logpwr_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  axi_logpwr_sched_if.slave         s_in,
  axi_logpwr_sched_if.master        m_out
);

  // Accept a new beat whenever the slot is empty or being drained this cycle.
  assign s_in.tready = ~m_out.tvalid | m_out.tready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_out.tvalid <= 1'b0;
      m_out.tdata  <= '0;
      m_out.tlast  <= 1'b0;
      m_out.tuser  <= SRC0;
    end else if (s_in.tvalid && s_in.tready) begin
      m_out.tvalid <= 1'b1;
      m_out.tdata  <= s_in.tdata;
      m_out.tlast  <= s_in.tlast;
      m_out.tuser  <= s_in.tuser;
    end else if (m_out.tready) begin
      m_out.tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_logpwr_sched.sv
// rtl/axi_logpwr_sched.sv - two-requester frame arbiter feeding the shared logpwr pipeline
module axi_logpwr_sched
  import axi_logpwr_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i0_tdata,
  input  logic             i0_tlast,
  input  logic             i0_tvalid,
  output logic             i0_tready,
  input  logic [WIDTH-1:0] i1_tdata,
  input  logic             i1_tlast,
  input  logic             i1_tvalid,
  output logic             i1_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             o_tuser,
  input  logic [1:0]       en,
  input  logic             clr,
  output logic [15:0]      frame_cnt0,
  output logic [15:0]      frame_cnt1,
  output logic             len_err
);

  localparam int            CW       = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_LEN - 1);

  state_e           r_state, w_next;
  logic             r_last_gnt, w_last_gnt_nxt;
  logic [CW-1:0]    r_beat_cnt;
  logic [15:0]      r_frame_cnt0, r_frame_cnt1;
  logic             r_len_err;

  logic             w_req0, w_req1, w_granted, w_src;
  logic             w_sel_valid, w_sel_last, w_at_limit;
  logic             w_accept, w_force, w_frame_end;
  logic [WIDTH-1:0] w_sel_data;

  axi_logpwr_sched_if #(.WIDTH(WIDTH)) w_pipe_in ();
  axi_logpwr_sched_if #(.WIDTH(WIDTH)) w_pipe_out ();

  assign w_req0      = en[0] & i0_tvalid;
  assign w_req1      = en[1] & i1_tvalid;
  assign w_granted   = (r_state != ST_IDLE);
  assign w_src       = (r_state == ST_GNT1) ? SRC1 : SRC0;
  assign w_sel_valid = w_src ? i1_tvalid : i0_tvalid;
  assign w_sel_last  = w_src ? i1_tlast  : i0_tlast;
  assign w_sel_data  = w_src ? i1_tdata  : i0_tdata;
  assign w_at_limit  = (r_beat_cnt == LAST_IDX);

  assign w_accept    = w_granted & w_sel_valid & w_pipe_in.tready;
  assign w_force     = w_accept & ~w_sel_last & w_at_limit;
  assign w_frame_end = w_accept & (w_sel_last | w_at_limit);

  assign i0_tready = (r_state == ST_GNT0) & w_pipe_in.tready;
  assign i1_tready = (r_state == ST_GNT1) & w_pipe_in.tready;

  assign w_pipe_in.tvalid = w_granted & w_sel_valid;
  assign w_pipe_in.tdata  = w_sel_data;
  assign w_pipe_in.tlast  = w_sel_last | w_at_limit;
  assign w_pipe_in.tuser  = w_src;

  axi_pipe_reg u_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .s_in    (w_pipe_in),
    .m_out   (w_pipe_out)
  );

  assign w_pipe_out.tready = o_tready;
  assign o_tdata  = w_pipe_out.tdata;
  assign o_tlast  = w_pipe_out.tlast;
  assign o_tvalid = w_pipe_out.tvalid;
  assign o_tuser  = w_pipe_out.tuser;

  // Arbitration happens only in IDLE; a grant is held until its frame end is accepted.
  always_comb begin
    w_next         = r_state;
    w_last_gnt_nxt = r_last_gnt;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 && w_req1) begin
          if (r_last_gnt == SRC1) begin
            w_next         = ST_GNT0;
            w_last_gnt_nxt = SRC0;
          end else begin
            w_next         = ST_GNT1;
            w_last_gnt_nxt = SRC1;
          end
        end else if (w_req0) begin
          w_next         = ST_GNT0;
          w_last_gnt_nxt = SRC0;
        end else if (w_req1) begin
          w_next         = ST_GNT1;
          w_last_gnt_nxt = SRC1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (w_frame_end) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= SRC1;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_last_gnt <= w_last_gnt_nxt;
      if (w_frame_end) r_beat_cnt <= '0;
      else if (w_accept) r_beat_cnt <= r_beat_cnt + CW'(1);
    end
  end

  // clr wins over any same-cycle increment or error set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt0 <= '0;
      r_frame_cnt1 <= '0;
      r_len_err    <= 1'b0;
    end else if (clr) begin
      r_frame_cnt0 <= '0;
      r_frame_cnt1 <= '0;
      r_len_err    <= 1'b0;
    end else begin
      if (w_frame_end && (w_src == SRC0)) r_frame_cnt0 <= r_frame_cnt0 + 16'd1;
      if (w_frame_end && (w_src == SRC1)) r_frame_cnt1 <= r_frame_cnt1 + 16'd1;
      if (w_force) r_len_err <= 1'b1;
    end
  end

  assign frame_cnt0 = r_frame_cnt0;
  assign frame_cnt1 = r_frame_cnt1;
  assign len_err    = r_len_err;

endmodule

// File: tb/tb_axi_logpwr_sched.sv
// tb/tb_axi_logpwr_sched.sv - directed self-checking bench for axi_logpwr_sched
module tb_axi_logpwr_sched;
  import axi_logpwr_pkg::*;

  localparam int W  = 32;
  localparam int ML = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clr = 1'b0;
  logic [1:0]  en = 2'b11;
  logic [15:0] frame_cnt0, frame_cnt1;
  logic        len_err;

  axi_logpwr_sched_if #(.WIDTH(W)) s0 ();
  axi_logpwr_sched_if #(.WIDTH(W)) s1 ();
  axi_logpwr_sched_if #(.WIDTH(W)) m ();

  always #5 clk = ~clk;

  axi_logpwr_sched #(.WIDTH(W), .MAX_LEN(ML)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i0_tdata   (s0.tdata),
    .i0_tlast   (s0.tlast),
    .i0_tvalid  (s0.tvalid),
    .i0_tready  (s0.tready),
    .i1_tdata   (s1.tdata),
    .i1_tlast   (s1.tlast),
    .i1_tvalid  (s1.tvalid),
    .i1_tready  (s1.tready),
    .o_tdata    (m.tdata),
    .o_tlast    (m.tlast),
    .o_tvalid   (m.tvalid),
    .o_tready   (m.tready),
    .o_tuser    (m.tuser),
    .en         (en),
    .clr        (clr),
    .frame_cnt0 (frame_cnt0),
    .frame_cnt1 (frame_cnt1),
    .len_err    (len_err)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  typedef struct {
    logic         user;
    logic [W-1:0] data;
    logic         last;
    int           cyc;
  } cap_t;

  typedef struct {
    logic         user;
    logic [W-1:0] data;
    logic         last;
    int           gap;
  } vec_t;

  beat_t q0[$];
  beat_t q1[$];
  cap_t  cap[$];
  int    cyc = 0;
  int    n1_fired = 0;
  bit    fire0 = 0, fire1 = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  always @(posedge clk) begin
    cyc   = cyc + 1;
    fire0 = s0.tvalid & s0.tready;
    fire1 = s1.tvalid & s1.tready;
    if (reset_n && m.tvalid && m.tready)
      cap.push_back('{m.tuser, m.tdata, m.tlast, cyc});
  end

  always @(negedge clk) begin
    if (fire0 && q0.size() > 0) q0.delete(0);
    if (fire1 && q1.size() > 0) begin
      q1.delete(0);
      n1_fired = n1_fired + 1;
    end
    fire0 = 0;
    fire1 = 0;
    s0.tvalid = (q0.size() > 0);
    s1.tvalid = (q1.size() > 0);
    if (q0.size() > 0) begin
      s0.tdata = q0[0].data;
      s0.tlast = q0[0].last;
    end else begin
      s0.tdata = '0;
      s0.tlast = 1'b0;
    end
    if (q1.size() > 0) begin
      s1.tdata = q1[0].data;
      s1.tlast = q1[0].last;
    end else begin
      s1.tdata = '0;
      s1.tlast = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cap(input string name, input int n, input int budget);
    int k = 0;
    while (cap.size() < n && k < budget) begin
      step();
      k++;
    end
    check(name, 32'(cap.size()), 32'(n));
  endtask

  task automatic push(input logic src, input logic [W-1:0] base, input int len, input int last_at);
    for (int i = 0; i < len; i++) begin
      if (src == SRC0) q0.push_back('{base + W'(i), (i == last_at)});
      else             q1.push_back('{base + W'(i), (i == last_at)});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tie_vec[12];
    int   k;
    int   base;
    bit   seen;

    tie_vec = '{
      '{1'b0, 32'hA000_0001, 1'b0, 0}, '{1'b0, 32'hA000_0002, 1'b0, 1}, '{1'b0, 32'hA000_0003, 1'b1, 1},
      '{1'b1, 32'hB000_0001, 1'b0, 2}, '{1'b1, 32'hB000_0002, 1'b0, 1}, '{1'b1, 32'hB000_0003, 1'b1, 1},
      '{1'b0, 32'hA000_0011, 1'b0, 2}, '{1'b0, 32'hA000_0012, 1'b0, 1}, '{1'b0, 32'hA000_0013, 1'b1, 1},
      '{1'b1, 32'hB000_0011, 1'b0, 2}, '{1'b1, 32'hB000_0012, 1'b0, 1}, '{1'b1, 32'hB000_0013, 1'b1, 1}
    };

    m.tready  = 1'b1;
    s0.tvalid = 1'b0; s0.tdata = '0; s0.tlast = 1'b0; s0.tuser = 1'b0;
    s1.tvalid = 1'b0; s1.tdata = '0; s1.tlast = 1'b0; s1.tuser = 1'b0;

    repeat (2) step();
    check("rst_o_tvalid", 32'(m.tvalid), 0);
    check("rst_o_tdata", m.tdata, 0);
    check("rst_o_tlast", 32'(m.tlast), 0);
    check("rst_o_tuser", 32'(m.tuser), 0);
    check("rst_frame_cnt0", 32'(frame_cnt0), 0);
    check("rst_frame_cnt1", 32'(frame_cnt1), 0);
    check("rst_len_err", 32'(len_err), 0);
    check("rst_i0_tready", 32'(s0.tready), 0);
    check("rst_i1_tready", 32'(s1.tready), 0);
    reset_n = 1'b1;
    step();

    // Tie-break: both sources valid together, alternating 3-beat frames.
    for (int i = 0; i < 12; i++)
      if (tie_vec[i].user == SRC0) q0.push_back('{tie_vec[i].data, tie_vec[i].last});
      else                         q1.push_back('{tie_vec[i].data, tie_vec[i].last});
    wait_cap("tie_count", 12, 80);
    for (int i = 0; i < 12; i++) begin
      if (i < cap.size()) begin
        check($sformatf("tie_user[%0d]", i), 32'(cap[i].user), 32'(tie_vec[i].user));
        check($sformatf("tie_data[%0d]", i), cap[i].data, tie_vec[i].data);
        check($sformatf("tie_last[%0d]", i), 32'(cap[i].last), 32'(tie_vec[i].last));
        if (tie_vec[i].gap > 0)
          check($sformatf("tie_gap[%0d]", i), 32'(cap[i].cyc - cap[i-1].cyc), 32'(tie_vec[i].gap));
      end
    end
    check("tie_frame_cnt0", 32'(frame_cnt0), 2);
    check("tie_frame_cnt1", 32'(frame_cnt1), 2);
    check("tie_len_err", 32'(len_err), 0);
    cap.delete();

    // Back-pressure mid-frame.
    push(SRC0, 32'hC000_0000, 6, 5);
    wait_cap("bp_pre", 2, 30);
    m.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_o_tvalid", 32'(m.tvalid), 1);
      check("bp_o_tdata", m.tdata, 32'hC000_0000 + 32'(cap.size()));
      check("bp_i0_tready", 32'(s0.tready), 0);
    end
    m.tready = 1'b1;
    wait_cap("bp_count", 6, 30);
    for (int i = 0; i < 6; i++) begin
      if (i < cap.size()) begin
        check($sformatf("bp_data[%0d]", i), cap[i].data, 32'hC000_0000 + 32'(i));
        check($sformatf("bp_last[%0d]", i), 32'(cap[i].last), 32'(i == 5));
      end
    end
    step();
    check("bp_frame_cnt0", 32'(frame_cnt0), 3);
    cap.delete();

    // Forced frame end at MAX_LEN.
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_frame_cnt0", 32'(frame_cnt0), 0);
    check("clr_frame_cnt1", 32'(frame_cnt1), 0);
    push(SRC0, 32'hD000_0000, 10, 9);
    wait_cap("force_count", 10, 60);
    for (int i = 0; i < 10; i++) begin
      if (i < cap.size()) begin
        check($sformatf("force_data[%0d]", i), cap[i].data, 32'hD000_0000 + 32'(i));
        check($sformatf("force_last[%0d]", i), 32'(cap[i].last), 32'((i == 7) || (i == 9)));
      end
    end
    if (cap.size() >= 9) check("force_gap", 32'(cap[8].cyc - cap[7].cyc), 2);
    step();
    check("force_len_err", 32'(len_err), 1);
    check("force_frame_cnt0", 32'(frame_cnt0), 2);
    cap.delete();

    // Masking: i1 permanently valid but disabled.
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_len_err", 32'(len_err), 0);
    en = 2'b01;
    push(SRC1, 32'hE100_0000, 2, 1);
    push(SRC0, 32'hE000_0000, 2, 1);
    push(SRC0, 32'hE000_0010, 2, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s1.tready) seen = 1;
    end
    check("mask_i1_tready", 32'(seen), 0);
    check("mask_count", 32'(cap.size()), 4);
    k = 0;
    foreach (cap[i]) if (cap[i].user != SRC0) k++;
    check("mask_src1_beats", 32'(k), 0);
    check("mask_frame_cnt0", 32'(frame_cnt0), 2);
    check("mask_frame_cnt1", 32'(frame_cnt1), 0);
    q1.delete();
    en = 2'b11;
    step();
    cap.delete();

    // Counter wrap and clr colliding with a forced frame end.
    force dut.r_frame_cnt1 = 16'hFFFF;
    #1;
    release dut.r_frame_cnt1;
    push(SRC1, 32'hF000_0001, 1, 0);
    wait_cap("wrap_cap", 1, 20);
    step();
    check("wrap_frame_cnt1", 32'(frame_cnt1), 0);
    push(SRC1, 32'hF000_0002, 1, 0);
    wait_cap("inc_cap", 2, 20);
    step();
    check("inc_frame_cnt1", 32'(frame_cnt1), 1);
    base = n1_fired;
    push(SRC1, 32'hF100_0000, 9, 8);
    k = 0;
    while (!(s1.tready && s1.tvalid && (n1_fired == base + 7)) && k < 40) begin
      step();
      k++;
    end
    check("clr_sync_found", 32'(k < 40), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clrhit_frame_cnt1", 32'(frame_cnt1), 0);
    check("clrhit_len_err", 32'(len_err), 0);
    wait_cap("clrhit_cap", 11, 40);
    step();
    check("after_frame_cnt1", 32'(frame_cnt1), 1);
    check("after_len_err", 32'(len_err), 0);
    if (cap.size() >= 11) begin
      check("clrhit_forced_last", 32'(cap[9].last), 1);
      check("clrhit_tail_last", 32'(cap[10].last), 1);
    end
    cap.delete();

    // Reset in the middle of a source-1 frame.
    push(SRC1, 32'h9000_0000, 5, 4);
    wait_cap("midrst_pre", 2, 20);
    reset_n = 1'b0;
    #1;
    check("midrst_o_tvalid", 32'(m.tvalid), 0);
    check("midrst_o_tdata", m.tdata, 0);
    check("midrst_o_tlast", 32'(m.tlast), 0);
    check("midrst_o_tuser", 32'(m.tuser), 0);
    check("midrst_frame_cnt1", 32'(frame_cnt1), 0);
    check("midrst_len_err", 32'(len_err), 0);
    check("midrst_i0_tready", 32'(s0.tready), 0);
    check("midrst_i1_tready", 32'(s1.tready), 0);
    q1.delete();
    step();
    reset_n = 1'b1;
    cap.delete();
    push(SRC0, 32'h8000_0000, 1, 0);
    push(SRC1, 32'h8100_0000, 1, 0);
    wait_cap("postrst_cap", 2, 20);
    if (cap.size() >= 2) begin
      check("postrst_first_user", 32'(cap[0].user), 0);
      check("postrst_second_user", 32'(cap[1].user), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
